uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, 8N1 framing, LSB first: 1 start bit, 8 data bits, 1 stop bit, no parity.
- Companion to the team's uart_tx; same clocking parameters, so a uart_tx output can be looped straight into rx.
- Samples the asynchronous serial input at mid-bit and presents each received byte with a one-cycle valid strobe.
- Flags framing errors on a separate one-cycle strobe.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in bits/s.
- Derived, not overridable:
  - CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division; 5208 at defaults.
  - HALF_BIT = CLKS_PER_BIT/2; 2604 at defaults.
  - Constraint: CLKS_PER_BIT >= 4.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk; idle high.
- rx_data  output  8  last correctly framed byte; held until the next good byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
- rx_busy  output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values: rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, state=IDLE, counters=0, synchronizer flops=1.
- Reset is effective in any state; a frame in progress is abandoned with no strobe.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only; this adds 2 cycles of latency.
- Bit counter: clk_cnt, wide enough for CLKS_PER_BIT-1. bit_idx: 3 bits.
- IDLE:
  - rx_s==0 → START, clk_cnt=0.
  - Otherwise stay.
- START:
  - Increment clk_cnt. At clk_cnt==HALF_BIT-1, sample rx_s.
  - rx_s==0 → DATA, clk_cnt=0, bit_idx=0.
  - rx_s==1 → IDLE. This is a glitch reject: no strobe, rx_data unchanged.
- DATA:
  - At clk_cnt==CLKS_PER_BIT-1, sample rx_s into shift register bit [bit_idx], clk_cnt=0.
  - bit_idx==7 → STOP; otherwise bit_idx+1.
  - The first data sample lands one full bit after the start mid-point, so all samples are mid-bit.
- STOP:
  - At clk_cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: rx_data <= shift register, rx_valid=1 for exactly one cycle → IDLE.
  - rx_s==0: frame_err=1 for one cycle, rx_data unchanged → BREAK.
- BREAK:
  - Wait for rx_s==1, then → IDLE.
  - A held-low line (break condition) produces exactly one frame_err and never a spurious frame.
- rx_busy = (state != IDLE), registered with state. It falls in the same cycle as the rx_valid / frame_err pulse, except in BREAK, where it stays high until the line returns high.
- Back-to-back frames: a start edge is accepted in the first IDLE cycle after STOP. This tolerates a stop bit shortened by up to half a bit.
- rx_valid and frame_err are never high together.
- There is no consumer handshake; a byte not read before the next rx_valid is overwritten.
- End-to-end latency: rx_valid rises (9*CLKS_PER_BIT + HALF_BIT + 3) ±1 cycles after the rx falling edge of the start bit. At defaults that is 49479 cycles ≈ 989.6 µs.
- Baud tolerance: a sender within ±2% of BAUD_RATE must be received error-free.

Test Plan:
- Reset, rx=1 for 10 µs → rx_data=00, rx_valid=0, rx_busy=0, frame_err=0 throughout.
- Drive 8N1 frame 0xA5 at 9600 baud (bit period 104167 ns) → exactly one rx_valid pulse ~989.6 µs after start edge; rx_data=A5; rx_busy high from ~3 cycles after the edge until the pulse; frame_err never high.
- Frames 0xA5 then 0x3C back-to-back with single stop bits, then 0x00 and 0xFF → four rx_valid pulses, rx_data sequence A5, 3C, 00, FF; no frame_err.
- 1 µs low glitch on idle rx → rx_busy pulses for ~HALF_BIT cycles then returns to 0; no rx_valid, no frame_err, rx_data unchanged.
- Frame 0x55 with stop bit driven 0, line held low 2 ms, then high, then valid 0x3C → exactly one frame_err, no rx_valid for 0x55, rx_busy high until line high; then rx_valid with rx_data=3C.
- Assert rst mid-DATA of 0xA5, release, send 0x3C. Also loop uart_tx (same parameters) output into rx with tx_data A5 → no strobe for the aborted frame, rx_data=3C after the 0x3C frame; loopback yields rx_data=A5 with one rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, mid-bit sampling through a
// two-flop synchronizer. Good bytes appear on rx_data with a one-cycle
// rx_valid; a low stop bit gives a one-cycle frame_err and the receiver
// then waits in BREAK for the line to return high.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_busy_q, rx_busy_d;
    logic               frame_err_q, frame_err_d;

    logic rx_s;
    logic half_done;
    logic bit_done;

    assign rx_s      = sync_q[1];
    assign half_done = (clk_cnt_q == CNT_W'(HALF_BIT - 1));
    assign bit_done  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;

    // State and datapath registers; synchronizer resets to the idle-high level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync_q      <= '1;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state decision from the synchronized line and bit timing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rx_s) state_d = ST_START;
            ST_START: if (half_done) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (bit_done && (bit_idx_q == 3'd7)) state_d = ST_STOP;
            ST_STOP:  if (bit_done) state_d = rx_s ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counters, shift register and output strobes for the current state.
    always_comb begin
        sync_d      = {sync_q[0], rx};
        clk_cnt_d   = '0;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_START: begin
                if (half_done) begin
                    bit_idx_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
